pooling_average_ctrl: RTL and testbench

//  Sequencer for the global-average-pooling BRAM datapath (per-channel accumulator BRAM, byte-select mux, x1/196 scaler).

---
 rtl/pooling_average_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pooling_average_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_average_ctrl.sv
// pooling_average_ctrl: sequencer for the global-average-pooling BRAM datapath.
// Accumulates a packed IFM stream (4 x 8-bit channels per word, channel-fastest,
// pixel-major) into a per-channel accumulator BRAM by read-modify-write, then
// reads every channel back for the downstream layer.
// Optional build macro: POOL_CTRL_PERF_EN adds perf_cycles / perf_stall counters.
module pooling_average_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_num_pixels,
  input  logic [CNT_W-1:0]  cfg_num_words,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dp_valid,
  output logic [1:0]        dp_control,
  output logic              dp_init,
  output logic              dp_we,
  output logic [ADDR_W-1:0] dp_rd_addr,
  output logic [ADDR_W-1:0] dp_wr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_channel,
  output logic              busy,
  output logic              done
`ifdef POOL_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  // Channel index = word*4 + byte, so it needs two more bits than the word count.
  localparam int CH_W = CNT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t            state;

  // Read side: rd_ch is the next channel address to read, rd_pix its pixel.
  logic [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_pix;
  logic [CH_W-1:0]   last_ch;
  logic [CNT_W-1:0]  last_pix;

  // Write side trails the read by one cycle (BRAM read data arrives then).
  logic              we_p1;
  logic              init_p1;
  logic [CH_W-1:0]   wr_ch_p1;

  // Read-back result stage.
  logic              out_vld_p1;
  logic [CH_W-1:0]   out_ch_p1;

  logic              rd_fire;
  logic              cfg_zero;

  // A new word is only taken once byte 3 of the previous word has been read;
  // rd_ch[1:0] is the byte of the next read, so byte 0 means "nothing held".
  assign in_ready    = (state == S_ACCUM) && (rd_ch[1:0] == 2'd0) && !abort;
  assign dp_valid    = in_ready && in_valid;
  assign rd_fire     = (state == S_ACCUM) && !abort && ((rd_ch[1:0] != 2'd0) || in_valid);

  assign dp_we       = we_p1 && !abort;
  assign dp_init     = init_p1;
  assign dp_control  = wr_ch_p1[1:0];
  assign dp_rd_addr  = ADDR_W'(rd_ch);
  assign dp_wr_addr  = ADDR_W'(wr_ch_p1);
  assign out_valid   = out_vld_p1;
  assign out_channel = ADDR_W'(out_ch_p1);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  assign cfg_zero    = (cfg_num_pixels == '0) || (cfg_num_words == '0);

  // Sequencer: counters, write stage and read-back stage, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_ch      <= '0;
      rd_pix     <= '0;
      last_ch    <= '0;
      last_pix   <= '0;
      we_p1      <= 1'b0;
      init_p1    <= 1'b0;
      wr_ch_p1   <= '0;
      out_vld_p1 <= 1'b0;
      out_ch_p1  <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      rd_ch      <= '0;
      rd_pix     <= '0;
      we_p1      <= 1'b0;
      init_p1    <= 1'b0;
      wr_ch_p1   <= '0;
      out_vld_p1 <= 1'b0;
      out_ch_p1  <= '0;
    end else begin
      we_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            last_ch  <= {cfg_num_words - CNT_W'(1), 2'b11};
            last_pix <= cfg_num_pixels - CNT_W'(1);
            rd_ch    <= '0;
            rd_pix   <= '0;
            state    <= cfg_zero ? S_DONE : S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (rd_fire) begin
            // read stage -> write stage
            we_p1    <= 1'b1;
            wr_ch_p1 <= rd_ch;
            init_p1  <= (rd_pix == '0);
            if (rd_ch == last_ch) begin
              rd_ch <= '0;
              if (rd_pix == last_pix) begin
                state <= S_DRAIN;
              end else begin
                rd_pix <= rd_pix + CNT_W'(1);
              end
            end else begin
              rd_ch <= rd_ch + CH_W'(1);
            end
          end
        end

        // The final write is on the bus during this cycle.
        S_DRAIN: begin
          rd_ch <= '0;
          state <= S_READ;
        end

        S_READ: begin
          if (!out_vld_p1) begin
            // address stage -> result stage
            out_vld_p1 <= 1'b1;
            out_ch_p1  <= rd_ch;
          end else if (out_ready) begin
            out_vld_p1 <= 1'b0;
            if (rd_ch == last_ch) begin
              rd_ch <= '0;
              state <= S_DONE;
            end else begin
              rd_ch <= rd_ch + CH_W'(1);
            end
          end
        end

        S_DONE: begin
          wr_ch_p1  <= '0;
          init_p1   <= 1'b0;
          out_ch_p1 <= '0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef POOL_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Busy-cycle and stall counters, cleared by an accepted start, frozen at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if ((state == S_IDLE) && start && !abort) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (state != S_IDLE) begin
        perf_cycles <= sat_inc(perf_cycles);
      end
      if ((in_ready && !in_valid) || ((state == S_READ) && out_vld_p1 && !out_ready)) begin
        perf_stall <= sat_inc(perf_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pooling_average_ctrl.sv
// Bench for pooling_average_ctrl: a behavioural datapath/BRAM model, a golden
// per-channel sum computed from the input words, and a per-cycle compare process.
module tb_pooling_average_ctrl;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  cfg_num_pixels;
  logic [CNT_W-1:0]  cfg_num_words;
  logic              in_valid;
  logic              in_ready;
  logic              dp_valid;
  logic [1:0]        dp_control;
  logic              dp_init;
  logic              dp_we;
  logic [ADDR_W-1:0] dp_rd_addr;
  logic [ADDR_W-1:0] dp_wr_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_channel;
  logic              busy;
  logic              done;
`ifdef POOL_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_stall;
`endif

  pooling_average_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .cfg_num_pixels (cfg_num_pixels),
    .cfg_num_words  (cfg_num_words),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dp_valid       (dp_valid),
    .dp_control     (dp_control),
    .dp_init        (dp_init),
    .dp_we          (dp_we),
    .dp_rd_addr     (dp_rd_addr),
    .dp_wr_addr     (dp_wr_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_channel    (out_channel),
    .busy           (busy),
    .done           (done)
`ifdef POOL_CTRL_PERF_EN
    ,
    .perf_cycles    (perf_cycles),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model state
  logic [31:0] data_in;
  logic [31:0] ifm_q;
  logic [31:0] bram_q;
  logic [31:0] bram [16];

  // Golden model / scoreboard state
  logic [31:0] words_q[$];
  int          golden [16];
  int          nch_m;
  int          wr_cnt, hs_cnt, acc_cnt, done_cnt;
  bit          rd_phase, prev_stall, exp_done_next, mon_en;
  logic [31:0] prev_ch, prev_addr, prev_data;

  int total;
  int bad;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] byte_of(input logic [31:0] w, input int b);
    return (w >> (8 * b)) & 32'hFF;
  endfunction

  function automatic int nonzero_outputs();
    int n;
    n = 0;
    n += int'(in_ready);
    n += int'(dp_valid);
    n += int'(dp_we);
    n += int'(dp_init);
    n += int'(dp_control != 2'd0);
    n += int'(dp_rd_addr != 0);
    n += int'(dp_wr_addr != 0);
    n += int'(out_valid);
    n += int'(out_channel != 0);
    n += int'(busy);
    n += int'(done);
    return n;
  endfunction

  // Per-channel sum over all pixels, straight from the stream layout.
  task automatic compute_golden(input int pix, input int wrd);
    for (int c = 0; c < 16; c++) golden[c] = 0;
    for (int p = 0; p < pix; p++)
      for (int c = 0; c < 4 * wrd; c++)
        golden[c] += int'(byte_of(words_q[p * wrd + c / 4], c % 4));
  endtask

  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // External datapath: 1-cycle sync read BRAM, IFM register, byte-select RMW add.
  task dp_model();
    forever begin
      @(posedge clk);
      bram_q <= bram[dp_rd_addr[3:0]];
      if (dp_we)
        bram[dp_wr_addr[3:0]] <= (dp_init ? 32'd0 : bram_q) + byte_of(ifm_q, int'(dp_control));
      if (dp_valid) ifm_q <= data_in;
    end
  endtask

  // Compare process: checks the DUT against the stream-level model each cycle.
  task monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dp_we) begin
          chk("wr_held", longint'(wr_cnt < 4 * hs_cnt), 1);
          chk("wr_addr", dp_wr_addr, wr_cnt % nch_m);
          chk("wr_ctrl", dp_control, (wr_cnt % nch_m) % 4);
          chk("wr_init", dp_init, longint'(wr_cnt < nch_m));
          chk("wr_in_read", rd_phase, 0);
          wr_cnt++;
        end
        if (dp_valid) begin
          chk("hs_in_valid", in_valid, 1);
          hs_cnt++;
        end
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_ch", out_channel, prev_ch);
          chk("stall_addr", dp_rd_addr, prev_addr);
          chk("stall_data", bram_q, prev_data);
        end
        if (exp_done_next || done) chk("done_latency", done, longint'(exp_done_next));
        exp_done_next = 1'b0;
        if (done) done_cnt++;
        if (out_valid) rd_phase = 1'b1;
        if (out_valid && out_ready) begin
          chk("out_ch", out_channel, acc_cnt);
          if (acc_cnt < 16) chk("out_data", bram_q, golden[acc_cnt]);
          acc_cnt++;
          if (acc_cnt == nch_m) exp_done_next = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_ch    = out_channel;
        prev_addr  = dp_rd_addr;
        prev_data  = bram_q;
      end
    end
  endtask

  // Drive one run; gmode: 0 none, 1 random in_valid gaps, 2 three gaps at ready.
  // smode: 0 always ready, 1 toggle, 2 two stalls. abort_hs>=0 aborts after that
  // many handshakes; rst_read pulls reset_n mid-READ; poke restarts while busy.
  task automatic run(input int pix, input int wrd, input int gmode, input int smode,
                     input int abort_hs, input bit rst_read, input bit poke);
    int idx, gaps, stalls;
    bit go, saw_done, stop;
    compute_golden(pix, wrd);
    for (int i = 0; i < 16; i++) bram[i] = 32'hA5A5_0000 + 32'(i);
    nch_m = 4 * wrd; wr_cnt = 0; hs_cnt = 0; acc_cnt = 0; done_cnt = 0;
    rd_phase = 0; prev_stall = 0; exp_done_next = 0;
    idx = 0; saw_done = 0; stop = 0;
    gaps   = (gmode == 2) ? 3 : 0;
    stalls = (smode == 2) ? 2 : 0;
    @(posedge clk); #1;
    cfg_num_pixels = CNT_W'(pix);
    cfg_num_words  = CNT_W'(wrd);
    start  = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 20000 && !saw_done && !stop; cyc++) begin
      if (poke && cyc == 20) begin
        start = 1'b1; cfg_num_pixels = 3; cfg_num_words = 1;
      end
      if (idx >= pix * wrd) in_valid = 1'b0;
      else if (gmode == 1) in_valid = ($urandom_range(0, 2) != 0);
      else if (gmode == 2 && gaps > 0 && in_ready) begin in_valid = 1'b0; gaps--; end
      else in_valid = 1'b1;
      data_in   = (idx < pix * wrd) ? words_q[idx] : 32'd0;
      out_ready = (smode == 0) ? 1'b1 : (smode == 1) ? ((cyc % 2) == 1) : (stalls == 0);
      @(negedge clk);
      go       = in_valid && in_ready;
      saw_done = done;
      if (out_valid && !out_ready && stalls > 0) stalls--;
      if (rst_read && out_valid) begin
        #2 reset_n = 1'b0;
        #1 chk("rst_outputs_zero", nonzero_outputs(), 0);
        mon_en = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        stop = 1;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        if (go) idx++;
        if (abort_hs >= 0 && idx == abort_hs) begin
          abort = 1'b1; in_valid = 1'b1;
          @(negedge clk);
          chk("abort_we", dp_we, 0);
          chk("abort_ready", in_ready, 0);
          @(posedge clk); #1;
          abort = 1'b0; in_valid = 1'b0;
          mon_en = 1'b0;
          @(negedge clk);
          chk("abort_outputs_zero", nonzero_outputs(), 0);
          chk("abort_busy", busy, 0);
          stop = 1;
        end
      end
    end
    mon_en = 1'b0;
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    if (!stop) begin
      chk("run_finished", saw_done, 1);
      chk("we_count", wr_cnt, 4 * pix * wrd);
      chk("out_count", acc_cnt, 4 * wrd);
      chk("done_count", done_cnt, 1);
      for (int c = 0; c < 4 * wrd; c++) chk("bram_sum", bram[c], golden[c]);
    end
  endtask

  initial begin
    int we_seen;
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_num_pixels = '0; cfg_num_words = '0; data_in = '0;
    ifm_q = '0; bram_q = '0; mon_en = 1'b0; nch_m = 1;
    for (int i = 0; i < 16; i++) bram[i] = '0;
    fork
      dp_model();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", nonzero_outputs(), 0);
    chk("reset_busy", busy, 0);
    @(negedge clk); reset_n = 1'b1;

    // T1: two pixels, one word, no gaps
    words_q.delete();
    words_q.push_back(32'h04030201);
    words_q.push_back(32'h01010101);
    run(2, 1, 0, 0, -1, 0, 0);
    chk("t1_golden0", golden[0], 2);
    chk("t1_golden3", golden[3], 5);
    chk("t1_bram0", bram[0], 2);
    chk("t1_bram1", bram[1], 3);
    chk("t1_bram2", bram[2], 4);
    chk("t1_bram3", bram[3], 5);
    chk("t1_we_total", wr_cnt, 8);

    // T2: 196 pixels, two words, random gaps, start/cfg poked while busy
    fill_random(196 * 2);
    run(196, 2, 1, 0, -1, 0, 1);
    chk("t2_we_total", wr_cnt, 1568);

    // T3: read-back with out_ready toggling
    fill_random(3);
    run(3, 1, 0, 1, -1, 0, 0);

    // T4: zero word count finishes straight away
    we_seen = 0;
    @(posedge clk); #1;
    cfg_num_pixels = 5; cfg_num_words = 0; start = 1'b1;
    @(negedge clk);
    chk("t4_idle_before", busy, 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("t4_done", done, 1);
    we_seen += int'(dp_we);
    @(negedge clk);
    chk("t4_done_once", done, 0);
    chk("t4_back_idle", busy, 0);
    we_seen += int'(dp_we);
    chk("t4_no_write", we_seen, 0);

    // T5: abort at pixel 5, reset mid-READ, then a clean run
    fill_random(196 * 2);
    run(196, 2, 0, 0, 11, 0, 0);
    fill_random(3 * 2);
    run(3, 2, 0, 0, -1, 1, 0);
    fill_random(2 * 2);
    run(2, 2, 1, 0, -1, 0, 0);

`ifdef POOL_CTRL_PERF_EN
    // T6: T1 with three input gaps and two output stalls
    words_q.delete();
    words_q.push_back(32'h04030201);
    words_q.push_back(32'h01010101);
    run(2, 1, 2, 2, -1, 0, 0);
    chk("t6_perf_stall", perf_stall, 5);
    chk("t6_perf_cycles", perf_cycles, 23);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
